// File: rtl/compfifo_readout_arb.sv
// Round-robin readout of per-fiber comparator FIFOs into a framed 16-bit GbE stream.
// Optional FRAME_CHECKSUM_EN adds an XOR checksum word (state CKS) before the trailer.
module compfifo_readout_arb #(
    parameter int NFIB    = 7,
    parameter int NWORDS  = 9,
    parameter int TIMEOUT = 255
)(
    input  logic                fabric_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NFIB-1:0]     fifo_dav,
    input  logic [48*NFIB-1:0]  fifo_dout,
    output logic [NFIB-1:0]     fifo_rd_en,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [15:0]         tx_dat,
    output logic                tx_sof,
    output logic                tx_eof,
    output logic                busy,
    output logic [2:0]          grant,
    output logic [15:0]         frame_count
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_HDR0,
        S_HDR1,
        S_RD,
        S_LAT,
        S_W2,
        S_W1,
        S_W0,
`ifdef FRAME_CHECKSUM_EN
        S_CKS,
`endif
        S_TRL
    } state_t;

    state_t        r_state;
    logic [2:0]    r_grant;
    logic [2:0]    r_ptr;
    logic [WW-1:0] r_wait;
    logic [3:0]    r_wcnt;
    logic          r_trunc;
    logic [31:0]   r_lo;
    logic [15:0]   r_fc;
    logic          r_valid;
    logic [15:0]   r_dat;
    logic          r_sof;
    logic          r_eof;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0]   r_cks;
`endif

    logic          w_xfer;
    logic          w_any;
    logic [2:0]    w_pick;
    logic [47:0]   w_dout;

    function automatic logic [2:0] f_pick(
        input logic [NFIB-1:0] dav,
        input logic [2:0]      ptr
    );
        logic [2:0] v_sel;
        logic [2:0] v_ix;
        v_sel = ptr;
        for (int k = NFIB - 1; k >= 0; k--) begin
            v_ix = 3'((int'(ptr) + k) % NFIB);
            if (dav[v_ix]) v_sel = v_ix;
        end
        return v_sel;
    endfunction

    function automatic logic [15:0] f_trl(
        input logic       t,
        input logic [3:0] n
    );
        return {8'hEF, t, 3'b000, n};
    endfunction

    assign w_xfer = r_valid & tx_ready;
    assign w_any  = |fifo_dav;
    assign w_pick = f_pick(fifo_dav, r_ptr);

    always_comb begin
        w_dout = '0;
        for (int i = 0; i < NFIB; i++)
            if (r_grant == 3'(i)) w_dout = fifo_dout[48*i +: 48];
    end

    // Decoded from state so the FIFO word lands exactly in LAT.
    assign fifo_rd_en = (r_state == S_RD && fifo_dav[r_grant])
                      ? (NFIB'(1) << r_grant) : '0;

    always_ff @(posedge fabric_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_wait  <= '0;
            r_wcnt  <= '0;
            r_trunc <= 1'b0;
            r_lo    <= '0;
            r_fc    <= '0;
            r_valid <= 1'b0;
            r_dat   <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_cks   <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (enable && w_any) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_wcnt  <= '0;
                        r_wait  <= '0;
                        r_trunc <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        r_cks   <= '0;
`endif
                        r_valid <= 1'b1;
                        r_sof   <= 1'b1;
                        r_dat   <= 16'hBC00 | {13'd0, w_pick};
                        r_state <= S_HDR0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HDR0: begin
                    if (w_xfer) begin
                        r_sof   <= 1'b0;
                        r_dat   <= r_fc;
                        r_state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (fifo_dav[r_grant]) begin
                        r_state <= S_LAT;
                    end else if (r_wait == WW'(TIMEOUT - 1)) begin
                        r_trunc <= 1'b1;
                        r_valid <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        r_dat   <= r_cks;
                        r_state <= S_CKS;
`else
                        r_dat   <= f_trl(1'b1, r_wcnt);
                        r_eof   <= 1'b1;
                        r_state <= S_TRL;
`endif
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_LAT: begin
                    r_lo    <= w_dout[31:0];
                    r_wcnt  <= r_wcnt + 4'd1;
                    r_wait  <= '0;
                    r_valid <= 1'b1;
                    r_dat   <= w_dout[47:32];
                    r_state <= S_W2;
                end
                S_W2: begin
                    if (w_xfer) begin
`ifdef FRAME_CHECKSUM_EN
                        r_cks   <= r_cks ^ r_dat;
`endif
                        r_dat   <= r_lo[31:16];
                        r_state <= S_W1;
                    end
                end
                S_W1: begin
                    if (w_xfer) begin
`ifdef FRAME_CHECKSUM_EN
                        r_cks   <= r_cks ^ r_dat;
`endif
                        r_dat   <= r_lo[15:0];
                        r_state <= S_W0;
                    end
                end
                S_W0: begin
                    if (w_xfer) begin
`ifdef FRAME_CHECKSUM_EN
                        r_cks <= r_cks ^ r_dat;
`endif
                        if (r_wcnt < 4'(NWORDS)) begin
                            r_valid <= 1'b0;
                            r_state <= S_RD;
                        end else begin
`ifdef FRAME_CHECKSUM_EN
                            r_dat   <= r_cks ^ r_dat;
                            r_state <= S_CKS;
`else
                            r_dat   <= f_trl(1'b0, r_wcnt);
                            r_eof   <= 1'b1;
                            r_state <= S_TRL;
`endif
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CKS: begin
                    if (w_xfer) begin
                        r_dat   <= f_trl(r_trunc, r_wcnt);
                        r_eof   <= 1'b1;
                        r_state <= S_TRL;
                    end
                end
`endif
                S_TRL: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_eof   <= 1'b0;
                        r_dat   <= '0;
                        r_fc    <= r_fc + 16'd1;
                        r_ptr   <= (r_grant == 3'(NFIB - 1))
                                 ? 3'd0 : r_grant + 3'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_valid    = r_valid;
    assign tx_dat      = r_dat;
    assign tx_sof      = r_sof;
    assign tx_eof      = r_eof;
    assign busy        = (r_state != S_IDLE);
    assign grant       = r_grant;
    assign frame_count = r_fc;

endmodule

// File: tb/tb_compfifo_readout_arb.sv
// Scoreboard bench for compfifo_readout_arb: FIFO model feeds the DUT,
// expected frame words are queued at load time and popped on each transfer.
module tb_compfifo_readout_arb;

    localparam int NFIB    = 7;
    localparam int NWORDS  = 9;
    localparam int TIMEOUT = 255;
`ifdef FRAME_CHECKSUM_EN
    localparam int CKW = 1;
`else
    localparam int CKW = 0;
`endif

    logic                fabric_clk = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic [NFIB-1:0]     fifo_dav = '0;
    logic [48*NFIB-1:0]  fifo_dout = '0;
    logic [NFIB-1:0]     fifo_rd_en;
    logic                tx_ready = 1'b0;
    logic                tx_valid;
    logic [15:0]         tx_dat;
    logic                tx_sof;
    logic                tx_eof;
    logic                busy;
    logic [2:0]          grant;
    logic [15:0]         frame_count;

    compfifo_readout_arb #(
        .NFIB(NFIB), .NWORDS(NWORDS), .TIMEOUT(TIMEOUT)
    ) dut (
        .fabric_clk (fabric_clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_dav   (fifo_dav),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_dat     (tx_dat),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .busy       (busy),
        .grant      (grant),
        .frame_count(frame_count)
    );

    always #5 fabric_clk = ~fabric_clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_rd [NFIB];
    int n_busy = 0;
    int n_xfer = 0;
    logic tog = 1'b0;
    logic stall_q = 1'b0;
    logic [17:0] held_q = '0;

    logic [47:0] fq    [NFIB][$];
    logic [47:0] ref_q [NFIB][$];
    logic [17:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Standard (non-FWFT) FIFO model: dout valid the cycle after rd_en.
    always @(posedge fabric_clk) begin
        if (fifo_rd_en != '0)
            check("rd_onehot", 32'($countones(fifo_rd_en)), 32'd1);
        for (int i = 0; i < NFIB; i++) begin
            if (fifo_rd_en[i]) begin
                n_rd[i]++;
                if (fq[i].size() == 0)
                    check("rd_empty", 32'd1, 32'd0);
                else
                    fifo_dout[48*i +: 48] <= fq[i].pop_front();
            end
            fifo_dav[i] <= (fq[i].size() != 0);
        end
    end

    always @(negedge fabric_clk) begin
        logic [17:0] e;
        if (busy) n_busy++;
        if (stall_q)
            check("stall_hold", {13'd0, tx_valid, tx_sof, tx_eof, tx_dat},
                  {13'd0, 1'b1, held_q});
        stall_q = tx_valid && !tx_ready;
        held_q  = {tx_sof, tx_eof, tx_dat};
        if (tx_valid && tx_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("extra_word", {14'd0, tx_sof, tx_eof, tx_dat}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("word", {14'd0, tx_sof, tx_eof, tx_dat}, {14'd0, e});
            end
        end
    end

    initial begin
        forever begin
            @(posedge fabric_clk);
            #1;
            tx_ready = tog ? ~tx_ready : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic load(input int fib, input int n);
        logic [63:0] t;
        for (int k = 0; k < n; k++) begin
            t = {$urandom(), $urandom()};
            fq[fib].push_back(t[47:0]);
            ref_q[fib].push_back(t[47:0]);
        end
    endtask

    task automatic expect_frame(input int fib, input logic [15:0] fc,
                                input int n, input logic trunc);
        logic [47:0] w;
        logic [15:0] cks;
        logic [3:0]  nw;
        cks = '0;
        nw  = 4'(n);
        exp_q.push_back({2'b10, 16'hBC00 | 16'(fib)});
        exp_q.push_back({2'b00, fc});
        for (int k = 0; k < n; k++) begin
            w = ref_q[fib].pop_front();
            exp_q.push_back({2'b00, w[47:32]});
            exp_q.push_back({2'b00, w[31:16]});
            exp_q.push_back({2'b00, w[15:0]});
            cks = cks ^ w[47:32] ^ w[31:16] ^ w[15:0];
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back({2'b00, cks});
`endif
        exp_q.push_back({2'b01, 8'hEF, trunc, 3'b000, nw});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge fabric_clk);
            k++;
        end
        if (k >= budget) check(tag, 32'd0, 32'd1);
    endtask

    task automatic clr_rd();
        for (int i = 0; i < NFIB; i++) n_rd[i] = 0;
    endtask

    task automatic pulse_reset();
        @(posedge fabric_clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge fabric_clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int k;
        clr_rd();
        repeat (3) @(posedge fabric_clk);
        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_dat", 32'(tx_dat), 32'd0);
        check("rst_sofeof", {30'd0, tx_sof, tx_eof}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_rden", 32'(fifo_rd_en), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge fabric_clk);
        #1;

        // single fiber, full-rate frame
        n_busy = 0;
        load(2, NWORDS);
        expect_frame(2, 16'd0, NWORDS, 1'b0);
        enable = 1'b1;
        wait_done(300, "t1_timeout");
        check("t1_rd", 32'(n_rd[2]), 32'(NWORDS));
        check("t1_fc", 32'(frame_count), 32'd1);
        check("t1_busy_cyc", 32'(n_busy), 32'(49 + CKW));
        check("t1_grant", 32'(grant), 32'd2);

        // same frame under back-pressure
        clr_rd();
        tog = 1'b1;
        load(2, NWORDS);
        expect_frame(2, 16'd1, NWORDS, 1'b0);
        wait_done(600, "t2_timeout");
        check("t2_rd", 32'(n_rd[2]), 32'(NWORDS));
        check("t2_fc", 32'(frame_count), 32'd2);
        tog = 1'b0;
        repeat (3) @(posedge fabric_clk);
        #1;

        // fibers 0 and 5 together from a reset pointer
        enable = 1'b0;
        pulse_reset();
        check("t3_fc_rst", 32'(frame_count), 32'd0);
        clr_rd();
        load(0, 2 * NWORDS);
        load(5, NWORDS);
        expect_frame(0, 16'd0, NWORDS, 1'b0);
        expect_frame(5, 16'd1, NWORDS, 1'b0);
        expect_frame(0, 16'd2, NWORDS, 1'b0);
        enable = 1'b1;
        wait_done(1000, "t3_timeout");
        check("t3_rd0", 32'(n_rd[0]), 32'(2 * NWORDS));
        check("t3_rd5", 32'(n_rd[5]), 32'(NWORDS));
        check("t3_fc", 32'(frame_count), 32'd3);

        // short event truncated by dav timeout
        clr_rd();
        @(posedge fabric_clk);
        #1;
        n_busy = 0;
        load(1, 4);
        expect_frame(1, 16'd3, 4, 1'b1);
        wait_done(800, "t4_timeout");
        check("t4_rd", 32'(n_rd[1]), 32'd4);
        check("t4_busy_cyc", 32'(n_busy), 32'(279 + CKW));
        check("t4_fc", 32'(frame_count), 32'd4);

        // enable dropped mid-frame: frame completes, then stays idle
        clr_rd();
        n_xfer = 0;
        load(4, 2 * NWORDS);
        expect_frame(4, 16'd4, NWORDS, 1'b0);
        k = 0;
        while (n_xfer < 5 && k < 200) begin
            @(negedge fabric_clk);
            k++;
        end
        if (k >= 200) check("t6_start", 32'd0, 32'd1);
        #1 enable = 1'b0;
        wait_done(300, "t6_timeout");
        repeat (20) @(negedge fabric_clk);
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_rd", 32'(n_rd[4]), 32'(NWORDS));
        check("t6_fc", 32'(frame_count), 32'd5);
        expect_frame(4, 16'd5, NWORDS, 1'b0);
        enable = 1'b1;
        wait_done(300, "t6b_timeout");
        check("t6b_fc", 32'(frame_count), 32'd6);

        // reset during W1 of the third word
        clr_rd();
        n_xfer = 0;
        load(3, NWORDS);
        expect_frame(3, 16'd6, NWORDS, 1'b0);
        k = 0;
        while (n_xfer < 9 && k < 200) begin
            @(negedge fabric_clk);
            k++;
        end
        if (k >= 200) check("t5_start", 32'd0, 32'd1);
        @(posedge fabric_clk);
        #1;
        check("t5_w1", {15'd0, tx_valid, tx_dat}, {15'd0, 1'b1, exp_q[0][15:0]});
        reset = 1'b0;
        #1;
        check("t5_valid", 32'(tx_valid), 32'd0);
        check("t5_dat", 32'(tx_dat), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_fc", 32'(frame_count), 32'd0);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_rden", 32'(fifo_rd_en), 32'd0);
        enable = 1'b0;
        exp_q.delete();
        fq[3].delete();
        ref_q[3].delete();
        repeat (3) @(posedge fabric_clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge fabric_clk);
        #1;
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_fc_after", 32'(frame_count), 32'd0);
        check("t5_rd", 32'(n_rd[3]), 32'd3);
        clr_rd();
        load(3, NWORDS);
        expect_frame(3, 16'd0, NWORDS, 1'b0);
        enable = 1'b1;
        wait_done(300, "t5b_timeout");
        check("t5b_rd", 32'(n_rd[3]), 32'(NWORDS));
        check("t5b_fc", 32'(frame_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/compfifo_readout_arb.md
Name: compfifo_readout_arb

Overview:
- Round-robin readout controller for the per-fiber comparator FIFOs (48-bit triad words, one FIFO per DCFEB fiber), in the fabric_clk domain.
- When a FIFO reports data available, the block grants that fiber and reads one event of NWORDS 48-bit words.
- Each word is serialized into three 16-bit words, framed with header and trailer, and streamed to the GbE transmit path under a valid/ready handshake.
- The block is the only source of rd_en to the comparator FIFOs.

Parameters:
- NFIB, 7, number of fiber FIFOs arbitrated (1..8).
- NWORDS, 9, 48-bit words read per event (3 triads); range 1..15.
- TIMEOUT, 255, fabric_clk cycles to wait for dav mid-event before truncating.

Ports:
- fabric_clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  permits new grants; a frame already in progress always completes.
- fifo_dav  in  NFIB  per-FIFO data available (= !empty).
- fifo_dout  in  48*NFIB  FIFO outputs; fiber i occupies bits [48i+47:48i].
- fifo_rd_en  out  NFIB  one-cycle read strobes; at most one bit high in any cycle.
- tx_ready  in  1  GbE path accepts tx_dat this cycle.
- tx_valid  out  1  tx_dat valid.
- tx_dat  out  16  frame word.
- tx_sof  out  1  high with the first header word.
- tx_eof  out  1  high with the trailer word.
- busy  out  1  high in any state other than IDLE.
- grant  out  3  fiber index currently or last granted.
- frame_count  out  16  completed-frame counter.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0 and state IDLE.
  - RR pointer, wait counter, word counter and frame_count cleared.
  - A reset mid-frame abandons the frame: no trailer is sent, and no fifo_rd_en is issued after reset.
- Transfer rule:
  - A word moves on a cycle where tx_valid&tx_ready.
  - While tx_valid&!tx_ready, tx_dat, tx_sof and tx_eof hold stable.
  - tx_valid never drops until the word is accepted.
- FIFO read latency: fifo_dout is valid the cycle after fifo_rd_en (standard, non-FWFT).
- FSM:
  - IDLE: if enable and |fifo_dav, go to ARB.
  - ARB: search fibers starting at the RR pointer and wrapping. Register grant = first fiber with dav high. Clear word count and wait count. Go to HDR0.
  - HDR0: tx_dat=16'hBC00|grant, tx_sof=1. On transfer go to HDR1.
  - HDR1: tx_dat=frame_count. On transfer go to RD.
  - RD:
    - If fifo_dav[grant]: assert fifo_rd_en[grant] for one cycle, go to LAT.
    - Otherwise increment the wait count. When it reaches TIMEOUT, set the truncate flag and go to TRL.
  - LAT: capture fifo_dout of the granted fiber into a 48-bit register. Increment the word count and clear the wait count. Go to W2.
  - W2, W1, W0: send bits [47:32], then [31:16], then [15:0], each advancing on transfer. After W0: go to RD if word count < NWORDS, else go to TRL.
  - TRL: tx_dat = 16'hEF00 | truncate<<7 | word count (bits 3:0). tx_eof=1. On transfer:
    - frame_count+1, wrapping 16'hFFFF->0.
    - RR pointer = grant+1, wrapping at NFIB.
    - Go to IDLE.
- Latency:
  - dav sampled high in IDLE at cycle N → ARB at N+1 → HDR0 with tx_valid at N+2.
  - With tx_ready held high, a full frame is 2+3*NWORDS+1 words.
  - Default frame is 30 words, taking 30+2*NWORDS = 48 cycles.
- Fairness:
  - Simultaneous dav on several fibers is served lowest index at or after the pointer.
  - A fiber cannot be granted twice in a row while another fiber's dav is high.
- enable=0 mid-frame: the frame completes normally, then the block stays in IDLE.
- Count width: the word count is 4 bits and never exceeds NWORDS.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- With the macro defined:
  - A 16-bit XOR of all W2/W1/W0 words sent in the frame is emitted as one extra word, state CKS, between the last data word (or a timeout) and TRL.
  - The checksum register clears in ARB.
  - Frame length becomes 2+3*NWORDS+2.
- Without the macro: there is no CKS state and the logic is absent.

Test Plan:
- Fiber 2 dav with 9 words loaded, tx_ready=1: BC02, 0000, then 27 data words in MSB-first order, then EF09 with eof; fifo_rd_en[2] pulses exactly 9 times; frame_count=1.
- Same frame with tx_ready toggling 1/0 every cycle: identical word sequence; tx_dat stable during every stall; no extra rd_en pulses.
- Fibers 0 and 5 dav simultaneously, reset pointer: frame for fiber 0, then fiber 5, then fiber 0 again. Headers BC00, BC05, BC00; frame_count fields 0, 1, 2.
- Fiber 1 holds only 4 words, then dav drops: after 255 idle cycles in RD, trailer EF84; no rd_en during the wait.
- reset pulled low during W1 of word 3: all outputs 0 immediately; after release, state IDLE and frame_count=0; a new dav starts a fresh frame with BC0x.
- With FRAME_CHECKSUM_EN: data words 1234, 5678, 9ABC as a single-word frame (NWORDS=1) give a CKS word of 16'hDEF0 before EF01.
